stack_ctrl: RTL and testbench

Stack-machine command sequencer that owns the control side of the `reg_file` operand stack. It accepts one stack operation per handshake, checks depth for underflow/overflow, drives the stack's pop/push strobes and write data, and performs the ALU step for arithmetic ops. It returns one response per command. It sits between the instruction decode stage and `reg_file`, and is the only block permitted to drive the stack's `en1`/`en2`/`we`/`din`.

---
 rtl/stack_pkg.sv | 44 ++++
 rtl/stack_alu.sv | 56 +++++
 rtl/stack_ctrl.sv | 141 ++++++++++++++
 tb/tb_stack_ctrl.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/stack_pkg.sv
// rtl/stack_pkg.sv - opcodes, per-op operand/depth constants and FSM state for stack_ctrl
package stack_pkg;

    localparam logic [2:0] OP_NOP  = 3'd0;
    localparam logic [2:0] OP_PUSH = 3'd1;
    localparam logic [2:0] OP_POP  = 3'd2;
    localparam logic [2:0] OP_ADD  = 3'd3;
    localparam logic [2:0] OP_SUB  = 3'd4;
    localparam logic [2:0] OP_DUP  = 3'd5;
    localparam logic [2:0] OP_SWAP = 3'd6;
    localparam logic [2:0] OP_PEEK = 3'd7;

    // Net effect of a completed op on stack occupancy
    typedef enum logic [1:0] {
        NET_ZERO = 2'd0,
        NET_INC  = 2'd1,
        NET_DEC  = 2'd2
    } net_t;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SWAP2 = 1'b1
    } state_t;

    // Number of stack words an op must find present before it may run
    function automatic logic [1:0] op_need(input logic [2:0] op);
        case (op)
            OP_POP, OP_DUP, OP_PEEK:  op_need = 2'd1;
            OP_ADD, OP_SUB, OP_SWAP:  op_need = 2'd2;
            default:                  op_need = 2'd0;
        endcase
    endfunction

    // Overall depth change of an op; SWAP is zero overall even though it
    // dips by one between its two cycles
    function automatic net_t op_net(input logic [2:0] op);
        case (op)
            OP_PUSH, OP_DUP:          op_net = NET_INC;
            OP_POP, OP_ADD, OP_SUB:   op_net = NET_DEC;
            default:                  op_net = NET_ZERO;
        endcase
    endfunction

endpackage

// File: rtl/stack_alu.sv
// rtl/stack_alu.sv - combinational per-op push value and response word
module stack_alu
    import stack_pkg::*;
#(
    parameter int DBITS = 32
) (
    input  logic [2:0]       op,
    input  logic [DBITS-1:0] imm,
    input  logic [DBITS-1:0] top,
    input  logic [DBITS-1:0] second,
    output logic [DBITS-1:0] result,
    output logic [DBITS-1:0] rsp
);

    logic [DBITS-1:0] sum;
    logic [DBITS-1:0] diff;

    assign sum  = second + top;
    assign diff = second - top;

    // result is what gets pushed in the accept cycle; rsp is the word returned
    always_comb begin
        result = '0;
        rsp    = '0;
        case (op)
            OP_PUSH: begin
                result = imm;
                rsp    = imm;
            end
            OP_POP, OP_PEEK: begin
                rsp = top;
            end
            OP_ADD: begin
                result = sum;
                rsp    = sum;
            end
            OP_SUB: begin
                result = diff;
                rsp    = diff;
            end
            OP_DUP: begin
                result = top;
                rsp    = top;
            end
            OP_SWAP: begin
                result = top;
                rsp    = second;
            end
            default: begin
                result = '0;
                rsp    = '0;
            end
        endcase
    end

endmodule

// File: rtl/stack_ctrl.sv
// rtl/stack_ctrl.sv - stack command sequencer driving reg_file pop/push strobes
module stack_ctrl
    import stack_pkg::*;
#(
    parameter int DBITS = 32,
    parameter int DEPTH = 16,
    parameter int DW    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [2:0]       cmd_op,
    input  logic [DBITS-1:0] cmd_imm,
    output logic             rsp_valid,
    output logic [DBITS-1:0] rsp_data,
    output logic             rsp_err,
    output logic [DW-1:0]    depth,
    output logic             full,
    output logic             empty,
    output logic             st_en1,
    output logic             st_en2,
    output logic             st_we,
    output logic [DBITS-1:0] st_din,
    input  logic [DBITS-1:0] st_dout1,
    input  logic [DBITS-1:0] st_dout2
);

    state_t           state;
    logic [DBITS-1:0] swap_q;
    logic [DBITS-1:0] alu_result;
    logic [DBITS-1:0] alu_rsp;
    logic [1:0]       need;
    net_t             net;
    logic             accept;
    logic             underflow;
    logic             overflow;
    logic             err;
    logic             ok;

    stack_alu #(.DBITS(DBITS)) u_alu (
        .op     (cmd_op),
        .imm    (cmd_imm),
        .top    (st_dout1),
        .second (st_dout2),
        .result (alu_result),
        .rsp    (alu_rsp)
    );

    // Ready is held low while reset is asserted, not just after it
    assign cmd_ready = rst && (state == ST_IDLE);
    assign accept    = cmd_valid && cmd_ready;

    assign need      = op_need(cmd_op);
    assign net       = op_net(cmd_op);
    assign underflow = depth < DW'(need);
    assign overflow  = (net == NET_INC) && full;
    assign err       = underflow || overflow;
    assign ok        = accept && !err;

    assign full  = (depth == DW'(DEPTH));
    assign empty = (depth == '0);

    // Stack strobes: only in the accept cycle, plus the second push of SWAP
    always_comb begin
        st_en1 = 1'b0;
        st_en2 = 1'b0;
        st_we  = 1'b0;
        st_din = alu_result;
        if (state == ST_SWAP2) begin
            st_we  = 1'b1;
            st_din = swap_q;
        end else if (ok) begin
            case (cmd_op)
                OP_PUSH, OP_DUP: begin
                    st_we = 1'b1;
                end
                OP_POP: begin
                    st_en1 = 1'b1;
                end
                OP_ADD, OP_SUB, OP_SWAP: begin
                    st_en1 = 1'b1;
                    st_en2 = 1'b1;
                    st_we  = 1'b1;
                end
                default: begin
                    st_we = 1'b0;
                end
            endcase
        end
    end

    // FSM, depth counter and one-cycle response register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= ST_IDLE;
            depth     <= '0;
            swap_q    <= '0;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_err   <= 1'b0;
        end else begin
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_err   <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        if (err) begin
                            rsp_valid <= 1'b1;
                            rsp_err   <= 1'b1;
                        end else if (cmd_op == OP_SWAP) begin
                            // old second is re-pushed next cycle and returned then
                            swap_q <= alu_rsp;
                            depth  <= depth - DW'(1);
                            state  <= ST_SWAP2;
                        end else begin
                            rsp_valid <= 1'b1;
                            rsp_data  <= alu_rsp;
                            case (net)
                                NET_INC: depth <= depth + DW'(1);
                                NET_DEC: depth <= depth - DW'(1);
                                default: depth <= depth;
                            endcase
                        end
                    end
                end
                ST_SWAP2: begin
                    depth     <= depth + DW'(1);
                    rsp_valid <= 1'b1;
                    rsp_data  <= swap_q;
                    state     <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_stack_ctrl.sv
// tb/tb_stack_ctrl.sv - directed table-driven bench for stack_ctrl with a behavioural stack
module tb_stack_ctrl;

    localparam int DBITS = 32;
    localparam int DEPTH = 16;
    localparam int DW    = $clog2(DEPTH + 1);

    localparam logic [2:0] NOP  = 3'd0;
    localparam logic [2:0] PUSH = 3'd1;
    localparam logic [2:0] POP  = 3'd2;
    localparam logic [2:0] ADD  = 3'd3;
    localparam logic [2:0] SUB  = 3'd4;
    localparam logic [2:0] DUP  = 3'd5;
    localparam logic [2:0] SWAP = 3'd6;
    localparam logic [2:0] PEEK = 3'd7;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             cmd_valid = 1'b0;
    logic             cmd_ready;
    logic [2:0]       cmd_op = 3'd0;
    logic [DBITS-1:0] cmd_imm = '0;
    logic             rsp_valid;
    logic [DBITS-1:0] rsp_data;
    logic             rsp_err;
    logic [DW-1:0]    depth;
    logic             full;
    logic             empty;
    logic             st_en1;
    logic             st_en2;
    logic             st_we;
    logic [DBITS-1:0] st_din;
    logic [DBITS-1:0] st_dout1;
    logic [DBITS-1:0] st_dout2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    stack_ctrl #(.DBITS(DBITS), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_imm   (cmd_imm),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data),
        .rsp_err   (rsp_err),
        .depth     (depth),
        .full      (full),
        .empty     (empty),
        .st_en1    (st_en1),
        .st_en2    (st_en2),
        .st_we     (st_we),
        .st_din    (st_din),
        .st_dout1  (st_dout1),
        .st_dout2  (st_dout2)
    );

    // Behavioural reg_file: en1/en2 pop, then we pushes
    logic [DBITS-1:0] mem [0:DEPTH-1];
    int sp = 0;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            sp <= 0;
        end else begin
            int nsp;
            nsp = sp - int'(st_en1) - int'(st_en2);
            if (st_we && nsp >= 0 && nsp < DEPTH) begin
                mem[nsp] <= st_din;
                nsp = nsp + 1;
            end
            sp <= nsp;
        end
    end

    assign st_dout1 = (sp > 0) ? mem[sp-1] : '0;
    assign st_dout2 = (sp > 1) ? mem[sp-2] : '0;

    typedef struct {
        logic [2:0]       op;
        logic [DBITS-1:0] imm;
        logic             exp_err;
        logic [DBITS-1:0] exp_data;
        int               exp_depth;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Present a command at the negedge and return 1ns after its accept edge
    task automatic do_cmd(input logic [2:0] op, input logic [DBITS-1:0] imm);
        int n;
        n = 0;
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_imm   = imm;
        while (!cmd_ready && n < 8) begin
            @(negedge clk);
            n++;
        end
        if (!cmd_ready) begin
            errors++;
            checks++;
            $display("FAIL accept_timeout: cmd_ready got 0 expected 1");
        end
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
    endtask

    task automatic cmd_chk(input string name, input logic [2:0] op, input logic [DBITS-1:0] imm,
                           input logic e_err, input logic [DBITS-1:0] e_data, input int e_depth);
        do_cmd(op, imm);
        chk({name, "_valid"}, 64'(rsp_valid), 64'(1));
        chk({name, "_err"},   64'(rsp_err),   64'(e_err));
        chk({name, "_data"},  64'(rsp_data),  64'(e_data));
        chk({name, "_depth"}, 64'(depth),     64'(e_depth));
    endtask

    initial begin
        vecs.push_back('{PUSH, 32'd0, 1'b0, 32'd0,        1});
        vecs.push_back('{PUSH, 32'd1, 1'b0, 32'd1,        2});
        vecs.push_back('{PUSH, 32'd2, 1'b0, 32'd2,        3});
        vecs.push_back('{PUSH, 32'd3, 1'b0, 32'd3,        4});
        vecs.push_back('{ADD,  32'd0, 1'b0, 32'd5,        3});
        vecs.push_back('{SUB,  32'd0, 1'b0, 32'hFFFFFFFC, 2});
        vecs.push_back('{POP,  32'd0, 1'b0, 32'hFFFFFFFC, 1});
        vecs.push_back('{POP,  32'd0, 1'b0, 32'd0,        0});
        vecs.push_back('{POP,  32'd0, 1'b1, 32'd0,        0});
        vecs.push_back('{PUSH, 32'd5, 1'b0, 32'd5,        1});
        vecs.push_back('{ADD,  32'd0, 1'b1, 32'd0,        1});
        vecs.push_back('{PEEK, 32'd0, 1'b0, 32'd5,        1});
        vecs.push_back('{DUP,  32'd0, 1'b0, 32'd5,        2});
        vecs.push_back('{NOP,  32'd9, 1'b0, 32'd0,        2});
        vecs.push_back('{POP,  32'd0, 1'b0, 32'd5,        1});
        vecs.push_back('{POP,  32'd0, 1'b0, 32'd5,        0});

        // Reset state
        #12;
        chk("rst_ready", 64'(cmd_ready), 64'(0));
        chk("rst_depth", 64'(depth), 64'(0));
        chk("rst_empty", 64'(empty), 64'(1));
        chk("rst_full",  64'(full), 64'(0));
        chk("rst_rsp_valid", 64'(rsp_valid), 64'(0));
        chk("rst_strobes", 64'({st_en1, st_en2, st_we}), 64'(0));
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("post_rst_ready", 64'(cmd_ready), 64'(1));

        // Table-driven sequence
        for (int i = 0; i < vecs.size(); i++) begin
            cmd_chk($sformatf("vec%0d", i), vecs[i].op, vecs[i].imm,
                    vecs[i].exp_err, vecs[i].exp_data, vecs[i].exp_depth);
        end
        chk("pop_to_empty", 64'(empty), 64'(1));
        @(posedge clk);
        #1;
        chk("rsp_one_cycle", 64'(rsp_valid), 64'(0));

        // Strobes for a legal PUSH, and none for an underflowing ADD
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_op    = PUSH;
        cmd_imm   = 32'hA5A5_0001;
        #1;
        chk("push_strobes", 64'({st_en1, st_en2, st_we}), 64'(3'b001));
        chk("push_din", 64'(st_din), 64'(32'hA5A5_0001));
        @(posedge clk);
        #1;
        cmd_op = ADD;
        #1;
        chk("add_uf_strobes", 64'({st_en1, st_en2, st_we}), 64'(0));
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        chk("add_uf_err", 64'(rsp_err), 64'(1));
        cmd_chk("pop_a5", POP, 32'd0, 1'b0, 32'hA5A5_0001, 0);

        // SWAP on [7,9]
        cmd_chk("push7", PUSH, 32'd7, 1'b0, 32'd7, 1);
        cmd_chk("push9", PUSH, 32'd9, 1'b0, 32'd9, 2);
        do_cmd(SWAP, 32'd0);
        chk("swap1_valid", 64'(rsp_valid), 64'(0));
        chk("swap1_ready", 64'(cmd_ready), 64'(0));
        chk("swap1_depth", 64'(depth), 64'(1));
        @(posedge clk);
        #1;
        chk("swap2_valid", 64'(rsp_valid), 64'(1));
        chk("swap2_data",  64'(rsp_data), 64'(7));
        chk("swap2_err",   64'(rsp_err), 64'(0));
        chk("swap2_depth", 64'(depth), 64'(2));
        chk("swap2_ready", 64'(cmd_ready), 64'(1));
        cmd_chk("swap_top", POP, 32'd0, 1'b0, 32'd7, 1);
        cmd_chk("swap_second", POP, 32'd0, 1'b0, 32'd9, 0);

        // Fill to capacity
        for (int i = 0; i < DEPTH; i++) begin
            do_cmd(PUSH, 32'(i + 100));
        end
        chk("fill_depth", 64'(depth), 64'(DEPTH));
        chk("fill_full", 64'(full), 64'(1));
        chk("fill_last_data", 64'(rsp_data), 64'(100 + DEPTH - 1));
        cmd_chk("push_full", PUSH, 32'd1, 1'b1, 32'd0, DEPTH);
        cmd_chk("dup_full",  DUP,  32'd0, 1'b1, 32'd0, DEPTH);
        cmd_chk("peek_full", PEEK, 32'd0, 1'b0, 32'(100 + DEPTH - 1), DEPTH);

        // Reset during SWAP2
        for (int i = 0; i < DEPTH - 2; i++) begin
            do_cmd(POP, 32'd0);
        end
        chk("pre_swap_depth", 64'(depth), 64'(2));
        do_cmd(SWAP, 32'd0);
        chk("mid_swap_ready", 64'(cmd_ready), 64'(0));
        rst = 1'b0;
        #1;
        chk("mid_rst_depth", 64'(depth), 64'(0));
        chk("mid_rst_valid", 64'(rsp_valid), 64'(0));
        chk("mid_rst_we", 64'(st_we), 64'(0));
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("after_rst_valid", 64'(rsp_valid), 64'(0));
        chk("after_rst_ready", 64'(cmd_ready), 64'(1));
        chk("after_rst_depth", 64'(depth), 64'(0));
        cmd_chk("after_rst_push", PUSH, 32'd42, 1'b0, 32'd42, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
